// File: rtl/program_loader_pkg.sv
// Shared constants and types for the program loader and the CPU control FSM.
// Word layout: opcode in [13:12], three 4-bit operand fields in [11:0].
package program_loader_pkg;

  localparam int DATA_W  = 14;
  localparam int ADDR_W  = 5;
  localparam int OPC_MSB = 13;
  localparam int OPC_LSB = 12;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RECV,
    S_WRITE,
    S_READ,
    S_CHECK,
    S_DONE,
    S_ERROR
  } ld_state_e;

endpackage

// File: rtl/program_loader_if.sv
// Host word stream, memory port and status bundle between the loader and its neighbours.
// The master side is the loader; the slave side is the host/memory/CPU glue.
interface program_loader_if;
  import program_loader_pkg::*;

  logic              start;
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_last;
  logic              in_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              cpu_hold;
  logic              busy;
  logic              done;
  logic              error;
  logic              overflow;
  logic [ADDR_W:0]   word_count;
  logic [DATA_W-1:0] checksum;

  modport master (
    input  start, in_data, in_valid, in_last, mem_rdata,
    output in_ready, mem_addr, mem_we, mem_wdata, cpu_hold,
           busy, done, error, overflow, word_count, checksum
  );

  modport slave (
    output start, in_data, in_valid, in_last, mem_rdata,
    input  in_ready, mem_addr, mem_we, mem_wdata, cpu_hold,
           busy, done, error, overflow, word_count, checksum
  );

endinterface

// File: rtl/program_loader.sv
// Streams host words into consecutive memory locations, reads each back to verify,
// and holds the CPU off the memory port until the whole program is in place.
module program_loader
  import program_loader_pkg::*;
#(
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int unsigned       DEPTH     = 32
) (
  input  logic              clk,
  input  logic              rst,
  program_loader_if.master  bus
);

  localparam int unsigned       LAST_INT  = 32'(BASE_ADDR) + DEPTH - 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(LAST_INT);

  ld_state_e         state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] word_q, word_d;
  logic              last_q, last_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [DATA_W-1:0] csum_q, csum_d;
  logic              in_ready_q, in_ready_d;
  logic              we_q, we_d;
  logic              hold_q, hold_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              error_q, error_d;
  logic              ovf_q, ovf_d;

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves one unassigned (no latch).
    state_d    = state_q;
    addr_d     = addr_q;
    word_d     = word_q;
    last_d     = last_q;
    count_d    = count_q;
    csum_d     = csum_q;
    hold_d     = hold_q;
    busy_d     = busy_q;
    done_d     = done_q;
    error_d    = error_q;
    ovf_d      = ovf_q;
    in_ready_d = 1'b0;
    we_d       = 1'b0;

    unique case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (bus.start) begin
          state_d    = S_RECV;
          addr_d     = BASE_ADDR;
          count_d    = '0;
          csum_d     = '0;
          done_d     = 1'b0;
          error_d    = 1'b0;
          ovf_d      = 1'b0;
          hold_d     = 1'b1;
          busy_d     = 1'b1;
          in_ready_d = 1'b1;
        end
      end
      S_RECV: begin
        if (bus.in_valid && in_ready_q) begin
          word_d  = bus.in_data;
          last_d  = bus.in_last;
          we_d    = 1'b1;
          state_d = S_WRITE;
        end else begin
          in_ready_d = 1'b1;
        end
      end
      S_WRITE: state_d = S_READ;
      S_READ:  state_d = S_CHECK;
      S_CHECK: begin
        if (bus.mem_rdata == word_q) begin
          count_d = count_q + 1'b1;
          csum_d  = csum_q + word_q;
          // Reaching the top address without in_last ends the load as an overflow.
          if (last_q || addr_q == LAST_ADDR) begin
            state_d = S_DONE;
            ovf_d   = !last_q;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            hold_d  = 1'b0;
          end else begin
            addr_d     = addr_q + 1'b1;
            state_d    = S_RECV;
            in_ready_d = 1'b1;
          end
        end else begin
          // CPU stays held and mem_addr keeps pointing at the bad location.
          state_d = S_ERROR;
          error_d = 1'b1;
          busy_d  = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      addr_q     <= BASE_ADDR;
      word_q     <= '0;
      last_q     <= 1'b0;
      count_q    <= '0;
      csum_q     <= '0;
      in_ready_q <= 1'b0;
      we_q       <= 1'b0;
      hold_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      word_q     <= word_d;
      last_q     <= last_d;
      count_q    <= count_d;
      csum_q     <= csum_d;
      in_ready_q <= in_ready_d;
      we_q       <= we_d;
      hold_q     <= hold_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      error_q    <= error_d;
      ovf_q      <= ovf_d;
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.mem_addr   = addr_q;
  assign bus.mem_we     = we_q;
  assign bus.mem_wdata  = word_q;
  assign bus.cpu_hold   = hold_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.error      = error_q;
  assign bus.overflow   = ovf_q;
  assign bus.word_count = count_q;
  assign bus.checksum   = csum_q;

endmodule
